// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, stall/redirect handling, IF/ID register
// and sticky fault detection for misaligned or out-of-range fetch addresses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_instruction,
    output logic [31:0] imem_address,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        fault
);

    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] instruction_next, pc_plus4_next;
    logic        valid_next, fault_next;

    logic        redirect;
    logic [31:0] target;
    logic        pc_legal;

    assign imem_address = pc;
    assign redirect     = jump | branch_taken;
    // jump outranks a simultaneous taken branch
    assign target       = jump ? jump_target : branch_target;
    assign pc_legal     = (pc[1:0] == 2'b00) && (pc <= LAST_PC);

    // NOTE: every output of this block gets a default before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instruction_next = if_instruction;
        pc_plus4_next    = if_pc_plus4;
        valid_next       = if_valid;
        fault_next       = fault;

        case (state)
            START: begin
                valid_next = 1'b0;
                state_next = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    // target legality is checked once it becomes the PC
                    pc_next    = target;
                    valid_next = 1'b0;
                end else if (!pc_legal) begin
                    state_next = HALT;
                    fault_next = 1'b1;
                    valid_next = 1'b0;
                end else if (!stall) begin
                    instruction_next = imem_instruction;
                    pc_plus4_next    = pc + 32'd4;
                    valid_next       = 1'b1;
                    pc_next          = pc + 32'd4;
                end
            end
            HALT: begin
                valid_next = 1'b0;
                fault_next = 1'b1;
            end
            default: state_next = START;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset is synchronous and overrides all other inputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= START;
            pc             <= RESET_PC;
            if_instruction <= 32'd0;
            if_pc_plus4    <= 32'd0;
            if_valid       <= 1'b0;
            fault          <= 1'b0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            if_instruction <= instruction_next;
            if_pc_plus4    <= pc_plus4_next;
            if_valid       <= valid_next;
            fault          <= fault_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-level reference model checked every cycle
// after reset, plus hand-computed literal checkpoints.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MEM_BYTES = 1024;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic [31:0] imem_instruction;
    logic [31:0] imem_address;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_target(jump_target),
        .imem_instruction(imem_instruction),
        .imem_address(imem_address),
        .if_instruction(if_instruction),
        .if_pc_plus4(if_pc_plus4),
        .if_valid(if_valid),
        .fault(fault)
    );

    always #5 clock = ~clock;

    // Memory image: upper half is the address, lower half its complement.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_instruction = mem_word(imem_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the fetch stage must hold after each rising edge.
    bit          m_known = 0;
    bit          m_start = 0;
    bit          m_halt  = 0;
    logic [31:0] m_pc, m_ins, m_p4;
    logic        m_valid, m_fault;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_known <= 1;
            m_start <= 1;
            m_halt  <= 0;
            m_pc    <= RESET_PC;
            m_ins   <= 32'd0;
            m_p4    <= 32'd0;
            m_valid <= 1'b0;
            m_fault <= 1'b0;
        end else if (m_known) begin
            if (m_start) begin
                m_start <= 0;
            end else if (!m_halt) begin
                if (jump || branch_taken) begin
                    m_pc    <= jump ? jump_target : branch_target;
                    m_valid <= 1'b0;
                end else if ((m_pc % 4) != 0 || m_pc > 32'(MEM_BYTES - 4)) begin
                    m_halt  <= 1;
                    m_fault <= 1'b1;
                    m_valid <= 1'b0;
                end else if (!stall) begin
                    m_ins   <= mem_word(m_pc);
                    m_p4    <= m_pc + 32'd4;
                    m_valid <= 1'b1;
                    m_pc    <= m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_known) begin
            check("model_imem_address", imem_address, m_pc);
            check("model_if_valid", {31'd0, if_valid}, {31'd0, m_valid});
            check("model_fault", {31'd0, fault}, {31'd0, m_fault});
            if (m_valid) begin
                check("model_if_instruction", if_instruction, m_ins);
                check("model_if_pc_plus4", if_pc_plus4, m_p4);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // Reset held for three edges
        repeat (3) step();
        check("rst_addr", imem_address, 32'h0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_ins", if_instruction, 32'h0);
        check("rst_p4", if_pc_plus4, 32'h0);
        reset_n = 1'b1;

        // Sequential fetch W0..W3
        step();
        check("start_valid", {31'd0, if_valid}, 32'd0);
        check("start_addr", imem_address, 32'h0);
        step();
        check("seq_w0", if_instruction, 32'h0000_FFFF);
        check("seq_p4_0", if_pc_plus4, 32'h4);
        check("seq_v0", {31'd0, if_valid}, 32'd1);
        step();
        check("seq_w1", if_instruction, 32'h0004_FFFB);
        check("seq_p4_1", if_pc_plus4, 32'h8);
        step();
        check("seq_w2", if_instruction, 32'h0008_FFF7);
        check("seq_p4_2", if_pc_plus4, 32'hC);
        step();
        check("seq_w3", if_instruction, 32'h000C_FFF3);
        check("seq_p4_3", if_pc_plus4, 32'h10);
        check("seq_addr", imem_address, 32'h10);

        // Mid-run reset, then stall at PC=8
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
        check("pre_stall_addr", imem_address, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", imem_address, 32'h8);
            check("stall_ins", if_instruction, 32'h0004_FFFB);
            check("stall_p4", if_pc_plus4, 32'h8);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        check("resume_ins", if_instruction, 32'h0008_FFF7);
        check("resume_p4", if_pc_plus4, 32'hC);
        check("resume_addr", imem_address, 32'hC);

        // Branch at PC=12, then jump+branch together
        branch_taken = 1'b1;
        branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        check("br_addr", imem_address, 32'h40);
        check("br_flush", {31'd0, if_valid}, 32'd0);
        step();
        check("br_ins", if_instruction, 32'h0040_FFBF);
        check("br_p4", if_pc_plus4, 32'h44);
        jump = 1'b1;
        branch_taken = 1'b1;
        jump_target = 32'h80;
        branch_target = 32'h40;
        step();
        jump = 1'b0;
        branch_taken = 1'b0;
        check("jmp_prio_addr", imem_address, 32'h80);
        check("jmp_flush", {31'd0, if_valid}, 32'd0);
        step();
        check("jmp_ins", if_instruction, 32'h0080_FF7F);

        // Redirect rescues an illegal PC; then a real misaligned fault
        jump = 1'b1;
        jump_target = 32'h102;
        step();
        check("mis_addr", imem_address, 32'h102);
        check("mis_nofault_yet", {31'd0, fault}, 32'd0);
        jump_target = 32'h10;
        step();
        jump = 1'b0;
        check("rescue_addr", imem_address, 32'h10);
        check("rescue_nofault", {31'd0, fault}, 32'd0);
        step();
        check("rescue_ins", if_instruction, 32'h0010_FFEF);
        jump = 1'b1;
        jump_target = 32'h102;
        step();
        jump = 1'b0;
        step();
        check("halt_fault", {31'd0, fault}, 32'd1);
        check("halt_addr", imem_address, 32'h102);
        check("halt_valid", {31'd0, if_valid}, 32'd0);
        jump = 1'b1;
        jump_target = 32'h0;
        repeat (2) step();
        jump = 1'b0;
        check("halt_ignores_jump", imem_address, 32'h102);
        check("halt_sticky", {31'd0, fault}, 32'd1);

        // Reset out of HALT
        reset_n = 1'b0;
        step();
        check("halt_rst_addr", imem_address, RESET_PC);
        check("halt_rst_fault", {31'd0, fault}, 32'd0);
        check("halt_rst_valid", {31'd0, if_valid}, 32'd0);
        reset_n = 1'b1;
        step();
        check("halt_rst_start", {31'd0, if_valid}, 32'd0);
        step();
        check("halt_rst_w0", if_instruction, 32'h0000_FFFF);

        // Reset while stalled at PC=0x20
        jump = 1'b1;
        jump_target = 32'h20;
        step();
        jump = 1'b0;
        stall = 1'b1;
        step();
        check("stall20_addr", imem_address, 32'h20);
        reset_n = 1'b0;
        step();
        check("stall_rst_addr", imem_address, RESET_PC);
        check("stall_rst_valid", {31'd0, if_valid}, 32'd0);
        reset_n = 1'b1;
        stall = 1'b0;
        repeat (2) step();
        check("stall_rst_w0", if_instruction, 32'h0000_FFFF);
        check("stall_rst_p4", if_pc_plus4, 32'h4);

        // Run off the end of memory
        for (int i = 0; i < 400 && !fault; i++) step();
        check("oor_fault", {31'd0, fault}, 32'd1);
        check("oor_addr", imem_address, 32'h400);
        check("oor_last_ins", if_instruction, 32'h03FC_FC03);
        check("oor_last_p4", if_pc_plus4, 32'h400);
        check("oor_valid", {31'd0, if_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
